// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared state encoding, sizing constants and the rotating priority search.
package rr_arbiter4_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam int NREQ = 4;
  localparam int MAX_HOLD_DEF = 8;
  // Scanning downward lets the lowest rotated offset win without an early exit.
  function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [NREQ-1:0] mask);
    logic [1:0] idx;
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (mask[idx]) pick = idx;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter4_decode24.sv
// decode24: 2-to-4 one-hot decoder.
module decode24
  import rr_arbiter4_pkg::*;
(
  input  logic [1:0]      in_idx,
  output logic [NREQ-1:0] onehot
);
  assign onehot = NREQ'(1) << in_idx;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a bounded hold time under contention.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 4
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_idx,
  output logic            grant_valid
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d, ptr_q, ptr_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [NREQ-1:0]  own, others;
  decode24 u_dec (.in_idx(idx_q), .onehot(own));
  assign grant       = valid_q ? own : '0;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    others  = req & ~own;
    nxt     = pick(idx_q + 2'd1, others);
    if (state_q == IDLE) begin
      if (|req) begin
        idx_d   = pick(ptr_q, req);
        ptr_d   = pick(ptr_q, req) + 2'd1;
        cnt_d   = '0;
        valid_d = 1'b1;
        state_d = BUSY;
      end
    end else if (!req[idx_q] || (|others && cnt_q == CNT_MAX)) begin
      // Release wins over timeout; both hand over directly when someone else waits.
      if (|others) begin
        idx_d = nxt;
        ptr_d = nxt + 2'd1;
        cnt_d = '0;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed and randomized checks of rr_arbiter4 against an owner/hold-time model.
module tb_rr_arbiter4;
  localparam int MH = 8;
  logic       CLK = 1'b0;
  logic       Reset_L = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_valid;
  int m_owner, m_ptr, m_held;

  rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );

  always #5 CLK = ~CLK;

  function automatic int first_from(input int s, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[(s + i) % 4]) return (s + i) % 4;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the resource and for how many visible cycles it has held it.
  always @(posedge CLK or negedge Reset_L) begin : model
    logic [3:0] oth;
    if (!Reset_L) begin
      m_valid = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (!m_valid) begin
      if (req != 0) begin
        m_owner = first_from(m_ptr, req);
        m_valid = 1; m_held = 1; m_ptr = (m_owner + 1) % 4;
      end
    end else begin
      oth = req;
      oth[m_owner] = 1'b0;
      if (!req[m_owner] || (oth != 0 && m_held == MH)) begin
        if (oth != 0) begin
          m_owner = first_from(m_owner + 1, oth);
          m_held = 1; m_ptr = (m_owner + 1) % 4;
        end else m_valid = 0;
      end else if (m_held < MH) m_held++;
    end
  end

  always @(negedge CLK) begin
    chk("cyc_valid", 32'(grant_valid), 32'(m_valid));
    chk("cyc_grant", 32'(grant), m_valid ? 32'(1 << m_owner) : 32'd0);
    if (m_valid) chk("cyc_idx", 32'(grant_idx), 32'(m_owner));
  end

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    Reset_L = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    @(posedge CLK);
    #2;
    Reset_L = 1'b1;
  endtask

  initial begin
    req = 4'b1111;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    chk("t1_rst_grant", 32'(grant), 32'd0);
    chk("t1_rst_valid", 32'(grant_valid), 32'd0);
    Reset_L = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(4'b1111);
      if (k == 0) chk("t1_idx", 32'(grant_idx), 32'd0);
      chk("t3_rot", 32'(grant), 32'(4'b0001 << ((k / 8) % 4)));
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(4'b0100);
      chk("t2_hold", 32'(grant), 32'h4);
    end
    step(4'b0000);
    chk("t2_idle_grant", 32'(grant), 32'd0);
    chk("t2_idle_valid", 32'(grant_valid), 32'd0);
    step(4'b0101);
    chk("t2_ptr3", 32'(grant), 32'h1);
    do_reset();
    step(4'b0010);
    chk("t4_own1", 32'(grant), 32'h2);
    step(4'b0010);
    step(4'b1001);
    chk("t4_handover", 32'(grant), 32'h8);
    chk("t4_noidle", 32'(grant_valid), 32'd1);
    step(4'b0001);
    chk("t4_to0", 32'(grant), 32'h1);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(4'b0010);
      chk("t5_sat", 32'(grant), 32'h2);
    end
    step(4'b0011);
    chk("t5_sat_timeout", 32'(grant), 32'h1);
    do_reset();
    step(4'b0100);
    chk("t6_own2", 32'(grant), 32'h4);
    Reset_L = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_valid", 32'(grant_valid), 32'd0);
    @(posedge CLK);
    #2;
    Reset_L = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) r[b] = ~r[b];
      if ($urandom_range(499) == 0) begin
        Reset_L = 1'b0;
        @(posedge CLK);
        #2;
        Reset_L = 1'b1;
      end
      step(r);
    end
    req = 4'b0000;
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
